one_six_bit: RTL and testbench

ONE_SIX_BIT -- requirements
Module: one_six_bit

---
 rtl/one_six_bit_pkg.sv | 13 +
 rtl/one_six_bit_cla4.sv | 24 ++
 rtl/one_six_bit.sv | 75 +++++++
 tb/tb_one_six_bit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/one_six_bit_pkg.sv
// one_six_bit_pkg: shared widths, group propagate/generate pair type and its 4-bit reduction
package one_six_bit_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int GROUP_W = 4;
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;
  function automatic pg_t group_pg(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g);
    group_pg.p = &p;
    group_pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction
endpackage

// File: rtl/one_six_bit_cla4.sv
// cla4: 4-bit lookahead slice (a,b,ci -> s, group propagate gp, group generate gg)
module cla4
  import one_six_bit_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] s,
  output logic               gp,
  output logic               gg
);
  logic [GROUP_W-1:0] g, p, c;
  pg_t pg;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign s = p ^ c;
  assign pg = group_pg(p, g);
  assign gp = pg.p;
  assign gg = pg.g;
endmodule

// File: rtl/one_six_bit.sv
// one_six_bit: registered two-level carry-lookahead adder (clk,rst,in_valid,a,b,cin -> sum,cout,out_valid; ovf when ONE_SIX_BIT_OVF_EN is defined)
module one_six_bit
  import one_six_bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef ONE_SIX_BIT_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int N = WIDTH / GROUP_W;
  logic [N-1:0] gp, gg;
  logic [N:0] cg;
  logic [WIDTH-1:0] s;
  logic term, acc;
  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_slice
      cla4 u_cla4 (
        .a (a[GROUP_W*i +: GROUP_W]),
        .b (b[GROUP_W*i +: GROUP_W]),
        .ci(cg[i]),
        .s (s[GROUP_W*i +: GROUP_W]),
        .gp(gp[i]),
        .gg(gg[i])
      );
    end
  endgenerate
  // each group carry is a flat sum of products over all lower groups and cin
  always_comb begin
    cg = '0;
    term = 1'b0;
    acc = 1'b0;
    cg[0] = cin;
    for (int k = 0; k < N; k++) begin
      term = cin;
      for (int m = 0; m <= k; m++) term = term & gp[m];
      acc = term;
      for (int j = 0; j <= k; j++) begin
        term = gg[j];
        for (int m = j + 1; m <= k; m++) term = term & gp[m];
        acc = acc | term;
      end
      cg[k+1] = acc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      cout <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      sum <= in_valid ? s : sum;
      cout <= in_valid ? cg[N] : cout;
    end
  end
`ifdef ONE_SIX_BIT_OVF_EN
  // carry into the msb recovered as s^p there
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else ovf <= in_valid ? (cg[N] ^ (s[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1])) : ovf;
  end
`endif
endmodule

// File: tb/tb_one_six_bit.sv
// tb_one_six_bit: self-checking bench for one_six_bit against an arithmetic reference model
module tb_one_six_bit;
  logic clk = 1'b0;
  logic rst, in_valid, cin;
  logic [15:0] a, b, sum;
  logic cout, out_valid;
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_sum;
  logic exp_cout;
`ifdef ONE_SIX_BIT_OVF_EN
  logic ovf;
  logic exp_ovf;
`endif

  one_six_bit #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .cin(cin),
    .sum(sum),
    .cout(cout),
    .out_valid(out_valid)
`ifdef ONE_SIX_BIT_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    rst = r;
    in_valid = v;
    a = x;
    b = y;
    cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    exp_sum = t[15:0];
    exp_cout = t[16];
`ifdef ONE_SIX_BIT_OVF_EN
    exp_ovf = (x[15] == y[15]) && (exp_sum[15] != x[15]);
`endif
  endtask

  task automatic test_reset();
    drive(1, 1, 16'hFFFF, 16'hFFFF, 1);
    drive(1, 1, 16'($urandom), 16'($urandom), 1);
    checks++;
    if (sum !== 16'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: sum=%h cout=%b ov=%b want 0000 0 0", sum, cout, out_valid);
    end
`ifdef ONE_SIX_BIT_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b want 0", ovf);
    end
`endif
  endtask

  task automatic test_directed();
    logic [48:0] vec [6];
    vec[0] = {16'hFFFF, 16'h0001, 1'b0, 16'h0000};
    vec[1] = {16'hAAAA, 16'h5555, 1'b0, 16'hFFFF};
    vec[2] = {16'h9249, 16'hCB6D, 1'b0, 16'h5DB6};
    vec[3] = {16'h49C7, 16'h8421, 1'b1, 16'hCDE9};
    vec[4] = {16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE};
    vec[5] = {16'h0000, 16'h0000, 1'b0, 16'h0000};
    // consecutive cycles with in_valid held high exercise full throughput
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, vec[i][48:33], vec[i][32:17], vec[i][16]);
      model(vec[i][48:33], vec[i][32:17], vec[i][16]);
      checks++;
      if (sum !== vec[i][15:0] || cout !== exp_cout || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed[%0d]: sum=%h cout=%b ov=%b want %h %b 1", i, sum, cout, out_valid, vec[i][15:0], exp_cout);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'($urandom), 16'($urandom), 1'($urandom));
      checks++;
      if (sum !== 16'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: sum=%h cout=%b ov=%b want 0000 0 0", i, sum, cout, out_valid);
      end
    end
  endtask

  task automatic test_reset_priority();
    drive(0, 1, 16'hFFFF, 16'hFFFF, 1);
    drive(1, 1, 16'hFFFF, 16'hFFFF, 0);
    checks++;
    if (sum !== 16'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: sum=%h cout=%b ov=%b want 0000 0 0", sum, cout, out_valid);
    end
    drive(0, 1, 16'h8000, 16'h8000, 1);
    checks++;
    if (sum !== 16'h0001 || cout !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: sum=%h cout=%b ov=%b want 0001 1 1", sum, cout, out_valid);
    end
  endtask

`ifdef ONE_SIX_BIT_OVF_EN
  task automatic test_ovf();
    drive(0, 1, 16'h7FFF, 16'h0001, 0);
    checks++;
    if (sum !== 16'h8000 || ovf !== 1'b1 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ovf: sum=%h ovf=%b cout=%b want 8000 1 0", sum, ovf, cout);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] x, y;
    logic c, v;
    drive(1, 0, 0, 0, 0);
    exp_sum = 0;
    exp_cout = 0;
`ifdef ONE_SIX_BIT_OVF_EN
    exp_ovf = 0;
`endif
    for (int i = 0; i < 10000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom);
      v = ($urandom_range(0, 7) != 0);
      if (i % 64 == 0) x = 16'hFFFF;
      drive(0, v, x, y, c);
      if (v) model(x, y, c);
      checks++;
      if (sum !== exp_sum || cout !== exp_cout || out_valid !== v) begin
        errors++;
        $display("FAIL random[%0d]: sum=%h cout=%b ov=%b want %h %b %b", i, sum, cout, out_valid, exp_sum, exp_cout, v);
      end
`ifdef ONE_SIX_BIT_OVF_EN
      checks++;
      if (ovf !== exp_ovf) begin
        errors++;
        $display("FAIL random_ovf[%0d]: ovf=%b want %b", i, ovf, exp_ovf);
      end
`endif
    end
  endtask

  initial begin
    rst = 1;
    in_valid = 0;
    a = 0;
    b = 0;
    cin = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_priority();
`ifdef ONE_SIX_BIT_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
